// File: rtl/csr_hpm_bank.sv
// rtl/csr_hpm_bank.sv - machine-mode counter bank: mcycle, minstret, mhpmcounters, events, mcountinhibit
module csr_hpm_bank #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 64,
    parameter int NUM_EVT = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               csr_wen,
    input  logic [11:0]        csr_waddr,
    input  logic [31:0]        csr_wdata,
    input  logic [11:0]        csr_raddr,
    output logic [31:0]        csr_rdata,
    output logic               csr_hit,
    input  logic               inst_commit,
    input  logic [NUM_EVT-1:0] events,
    output logic [NUM_CNT-1:0] ovf_pending,
    output logic               ovf_irq
);

    localparam int              NC       = (NUM_CNT > 0) ? NUM_CNT : 1;
    localparam logic [31:0]     HI_MASK  = 32'((64'h1 << (CNT_W - 32)) - 64'h1);
    localparam logic [31:0]     INH_MASK = 32'h5 | 32'(((64'h1 << NUM_CNT) - 64'h1) << 3);
    localparam logic [31:0]     EVT_MASK = 32'hC000_00FF;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] mcycle;
    logic [CNT_W-1:0] minstret;
    logic [CNT_W-1:0] cnt [NC];
    logic [7:0]       sel [NC];
    logic [NC-1:0]    ovfie;
    logic [NC-1:0]    of;
    logic [31:0]      inhibit;

    logic [255:0]     evt_pad;
    assign evt_pad = 256'(events);

    // Region decode: B00-B1F low halves, B80-B9F high halves, 320-33F events/inhibit
    logic       w_lo, w_hi, w_ev;
    logic [4:0] woff;
    assign w_lo = csr_wen && (csr_waddr[11:5] == 7'h58);
    assign w_hi = csr_wen && (csr_waddr[11:5] == 7'h5C);
    assign w_ev = csr_wen && (csr_waddr[11:5] == 7'h19);
    assign woff = csr_waddr[4:0];

    logic       r_lo, r_hi, r_ev;
    logic [4:0] roff;
    assign r_lo = (csr_raddr[11:5] == 7'h58);
    assign r_hi = (csr_raddr[11:5] == 7'h5C);
    assign r_ev = (csr_raddr[11:5] == 7'h19);
    assign roff = csr_raddr[4:0];

    logic [NC-1:0] cnt_wlo, cnt_whi, evt_wr, inc, ovf;

    always_comb begin
        cnt_wlo = '0;
        cnt_whi = '0;
        evt_wr  = '0;
        inc     = '0;
        ovf     = '0;
        for (int i = 0; i < NC; i++) begin
            if (i < NUM_CNT) begin
                cnt_wlo[i] = w_lo && (woff == 5'(i + 3));
                cnt_whi[i] = w_hi && (woff == 5'(i + 3));
                evt_wr[i]  = w_ev && (woff == 5'(i + 3));
                inc[i]     = (sel[i] != 8'd0) && (32'(sel[i]) < NUM_EVT) &&
                             evt_pad[sel[i]] && !inhibit[3 + i] &&
                             !cnt_wlo[i] && !cnt_whi[i];
                ovf[i]     = inc[i] && (&cnt[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mcycle   <= '0;
            minstret <= '0;
            inhibit  <= '0;
            ovfie    <= '0;
            of       <= '0;
            ovf_irq  <= 1'b0;
            for (int i = 0; i < NC; i++) begin
                cnt[i] <= '0;
                sel[i] <= '0;
            end
        end else begin
            if (w_lo && woff == 5'd0)
                mcycle[31:0] <= csr_wdata;
            else if (w_hi && woff == 5'd0)
                mcycle[CNT_W-1:32] <= csr_wdata[CNT_W-33:0];
            else if (!inhibit[0])
                mcycle <= mcycle + ONE;

            if (w_lo && woff == 5'd2)
                minstret[31:0] <= csr_wdata;
            else if (w_hi && woff == 5'd2)
                minstret[CNT_W-1:32] <= csr_wdata[CNT_W-33:0];
            else if (inst_commit && !inhibit[2])
                minstret <= minstret + ONE;

            if (w_ev && woff == 5'd0)
                inhibit <= csr_wdata & INH_MASK;

            for (int i = 0; i < NC; i++) begin
                if (cnt_wlo[i])
                    cnt[i][31:0] <= csr_wdata;
                else if (cnt_whi[i])
                    cnt[i][CNT_W-1:32] <= csr_wdata[CNT_W-33:0];
                else if (inc[i])
                    cnt[i] <= cnt[i] + ONE;

                // A wrap in the same cycle as a software write still records OF
                if (evt_wr[i]) begin
                    sel[i]   <= csr_wdata[7:0];
                    ovfie[i] <= csr_wdata[30];
                    of[i]    <= csr_wdata[31] | ovf[i];
                end else begin
                    of[i]    <= of[i] | ovf[i];
                end
            end

            ovf_irq <= |(of & ovfie);
        end
    end

    assign ovf_pending = of;

    logic        r_impl_cnt, r_impl_any;
    logic [31:0] rd_cur, rd_byp;

    always_comb begin
        r_impl_cnt = (32'(roff) >= 3) && (32'(roff) < 3 + NUM_CNT);
        r_impl_any = 1'b0;
        csr_hit    = ((r_lo || r_hi) && roff != 5'd1) || r_ev;
        rd_cur     = '0;
        rd_byp     = '0;
        if (r_lo || r_hi) begin
            r_impl_any = (roff == 5'd0) || (roff == 5'd2) || r_impl_cnt;
            if (roff == 5'd0)
                rd_cur = r_lo ? mcycle[31:0] : 32'(mcycle[CNT_W-1:32]);
            else if (roff == 5'd2)
                rd_cur = r_lo ? minstret[31:0] : 32'(minstret[CNT_W-1:32]);
            for (int i = 0; i < NC; i++) begin
                if (i < NUM_CNT && roff == 5'(i + 3))
                    rd_cur = r_lo ? cnt[i][31:0] : 32'(cnt[i][CNT_W-1:32]);
            end
            if (r_impl_any)
                rd_byp = r_lo ? csr_wdata : (csr_wdata & HI_MASK);
        end else if (r_ev) begin
            r_impl_any = (roff == 5'd0) || r_impl_cnt;
            if (roff == 5'd0)
                rd_cur = inhibit;
            for (int i = 0; i < NC; i++) begin
                if (i < NUM_CNT && roff == 5'(i + 3))
                    rd_cur = {of[i], ovfie[i], 22'd0, sel[i]};
            end
            if (roff == 5'd0)
                rd_byp = csr_wdata & INH_MASK;
            else if (r_impl_cnt)
                rd_byp = csr_wdata & EVT_MASK;
        end

        if (!csr_hit)
            csr_rdata = '0;
        else if (csr_wen && csr_waddr == csr_raddr)
            csr_rdata = rd_byp;
        else
            csr_rdata = rd_cur;
    end

endmodule

// File: tb/tb_csr_hpm_bank.sv
// tb/tb_csr_hpm_bank.sv - directed self-checking bench for csr_hpm_bank
module tb_csr_hpm_bank;

    logic        clk;
    logic        resetn;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        inst_commit;
    logic [15:0] events;
    logic [1:0]  ovf_pending;
    logic        ovf_irq;

    int checks   = 0;
    int failures = 0;

    csr_hpm_bank #(.NUM_CNT(2), .CNT_W(64), .NUM_EVT(16)) dut (
        .clk(clk),
        .resetn(resetn),
        .csr_wen(csr_wen),
        .csr_waddr(csr_waddr),
        .csr_wdata(csr_wdata),
        .csr_raddr(csr_raddr),
        .csr_rdata(csr_rdata),
        .csr_hit(csr_hit),
        .inst_commit(inst_commit),
        .events(events),
        .ovf_pending(ovf_pending),
        .ovf_irq(ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] e, input logic eh);
        csr_raddr = a;
        #1;
        check(tag, csr_rdata, e);
        check({tag, "_hit"}, {31'd0, csr_hit}, {31'd0, eh});
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wen   = 1'b1;
        csr_waddr = a;
        csr_wdata = d;
    endtask

    initial begin
        resetn = 1'b0; csr_wen = 1'b0; csr_waddr = '0; csr_wdata = '0;
        csr_raddr = '0; inst_commit = 1'b0; events = '0;
        tick(); tick();
        wr(12'hB03, 32'h77);
        tick();
        csr_wen = 1'b0;
        tick();

        resetn = 1'b1;
        rd("rst_mcycle", 12'hB00, 32'h0, 1'b1);
        check("rst_irq", {31'd0, ovf_irq}, 32'd0);
        check("rst_pending", {30'd0, ovf_pending}, 32'd0);
        tick();
        rd("mcycle_1", 12'hB00, 32'h1, 1'b1);
        tick();
        rd("rst_minstret", 12'hB02, 32'h0, 1'b1);
        tick();
        rd("rst_cnt0", 12'hB03, 32'h0, 1'b1);
        tick();
        rd("rst_evt0", 12'h323, 32'h0, 1'b1);

        // Overflow of counter 0 and the interrupt that follows
        wr(12'hB03, 32'hFFFF_FFFE);
        rd("byp_cnt0_lo", 12'hB03, 32'hFFFF_FFFE, 1'b1);
        tick();
        wr(12'hB83, 32'hFFFF_FFFF);
        rd("byp_cnt0_hi", 12'hB83, 32'hFFFF_FFFF, 1'b1);
        tick();
        wr(12'h323, 32'h4000_0005);
        events = 16'h0020;
        rd("byp_evt0", 12'h323, 32'h4000_0005, 1'b1);
        tick();
        csr_wen = 1'b0;
        rd("cnt0_pre", 12'hB03, 32'hFFFF_FFFE, 1'b1);
        tick();
        rd("cnt0_ones_lo", 12'hB03, 32'hFFFF_FFFF, 1'b1);
        rd("cnt0_ones_hi", 12'hB83, 32'hFFFF_FFFF, 1'b1);
        tick();
        rd("cnt0_wrap_lo", 12'hB03, 32'h0, 1'b1);
        rd("cnt0_wrap_hi", 12'hB83, 32'h0, 1'b1);
        rd("evt0_of", 12'h323, 32'hC000_0005, 1'b1);
        check("wrap_pending", {30'd0, ovf_pending}, 32'h1);
        check("wrap_irq_low", {31'd0, ovf_irq}, 32'd0);
        tick();
        events = '0;
        check("irq_high", {31'd0, ovf_irq}, 32'd1);
        rd("cnt0_after_wrap", 12'hB03, 32'h1, 1'b1);
        wr(12'h323, 32'h4000_0005);
        rd("byp_evt0_clr", 12'h323, 32'h4000_0005, 1'b1);
        tick();
        csr_wen = 1'b0;
        check("irq_lag", {31'd0, ovf_irq}, 32'd1);
        check("pending_clr", {30'd0, ovf_pending}, 32'd0);
        tick();
        check("irq_drop", {31'd0, ovf_irq}, 32'd0);

        // Bypass on mcycle halves; a written half does not also increment
        wr(12'hB80, 32'h12);
        rd("byp_mcycle_hi", 12'hB80, 32'h12, 1'b1);
        tick();
        wr(12'hB00, 32'h100);
        rd("byp_mcycle_lo", 12'hB00, 32'h100, 1'b1);
        tick();
        csr_wen = 1'b0;
        rd("mcycle_no_inc", 12'hB00, 32'h100, 1'b1);
        rd("mcycle_hi_held", 12'hB80, 32'h12, 1'b1);
        tick();
        rd("mcycle_resume", 12'hB00, 32'h101, 1'b1);

        // mcountinhibit on minstret
        inst_commit = 1'b1;
        tick(); tick();
        rd("minstret_2", 12'hB02, 32'h2, 1'b1);
        wr(12'h320, 32'hFFFF_FFFC);
        rd("byp_inhibit", 12'h320, 32'h1C, 1'b1);
        tick();
        csr_wen = 1'b0;
        rd("minstret_3", 12'hB02, 32'h3, 1'b1);
        rd("inhibit_rd", 12'h320, 32'h1C, 1'b1);
        tick();
        rd("minstret_frozen", 12'hB02, 32'h3, 1'b1);
        wr(12'h320, 32'h0);
        tick();
        csr_wen = 1'b0;
        rd("minstret_still", 12'hB02, 32'h3, 1'b1);
        tick();
        rd("minstret_resume", 12'hB02, 32'h4, 1'b1);
        inst_commit = 1'b0;

        // Unimplemented and unowned addresses
        wr(12'hB07, 32'h55);
        rd("byp_unimpl", 12'hB07, 32'h0, 1'b1);
        tick();
        csr_wen = 1'b0;
        rd("unimpl_b07", 12'hB07, 32'h0, 1'b1);
        rd("time_b01", 12'hB01, 32'h0, 1'b0);
        rd("timeh_b81", 12'hB81, 32'h0, 1'b0);
        tick();
        rd("nohit_300", 12'h300, 32'h0, 1'b0);
        rd("gap_321", 12'h321, 32'h0, 1'b1);
        rd("unimpl_evt", 12'h325, 32'h0, 1'b1);
        wr(12'h324, 32'h3FFF_FF0F);
        rd("byp_evt1_mask", 12'h324, 32'h0000_000F, 1'b1);
        tick();
        csr_wen = 1'b0;
        rd("evt1_rd", 12'h324, 32'h0000_000F, 1'b1);

        // Software clears the selector on the very cycle the counter wraps
        wr(12'hB83, 32'hFFFF_FFFF);
        tick();
        wr(12'hB03, 32'hFFFF_FFFF);
        tick();
        csr_wen = 1'b0;
        rd("cnt0_set_lo", 12'hB03, 32'hFFFF_FFFF, 1'b1);
        rd("cnt0_set_hi", 12'hB83, 32'hFFFF_FFFF, 1'b1);
        events = 16'h0020;
        wr(12'h323, 32'h0);
        tick();
        csr_wen = 1'b0;
        events = '0;
        rd("evt0_hw_of", 12'h323, 32'h8000_0000, 1'b1);
        rd("cnt0_wrap2", 12'hB03, 32'h0, 1'b1);
        check("wrap2_pending", {30'd0, ovf_pending}, 32'h1);
        events = 16'h0020;
        tick();
        events = '0;
        rd("cnt0_stopped", 12'hB03, 32'h0, 1'b1);
        check("wrap2_irq", {31'd0, ovf_irq}, 32'd0);

        // Reset in the middle of counting
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        rd("midrst_mcycle", 12'hB00, 32'h0, 1'b1);
        rd("midrst_evt0", 12'h323, 32'h0, 1'b1);
        check("midrst_pending", {30'd0, ovf_pending}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_hpm_bank.md
# csr_hpm_bank

Parametrised machine-mode counter bank for the CSR unit: mcycle/h, minstret/h, up to 29 mhpmcounterN/h with mhpmeventN selectors, and mcountinhibit. It generalises counter width and channel count and adds per-counter overflow flags with an overflow interrupt request. It sits beside the CSR register file. It decodes its own address range on the shared CSR read/write ports and returns a hit flag so the CSR read mux can select it.

## Interface
- NUM_CNT, 4, number of implemented mhpmcounters (indices 3..3+NUM_CNT-1); legal 0..29
- CNT_W, 64, counter width for all counters; legal 33..64
- NUM_EVT, 16, width of the event input vector; legal 2..256

- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- csr_wen  in  1  CSR write strobe
- csr_waddr  in  12  CSR write address
- csr_wdata  in  32  CSR write data
- csr_raddr  in  12  CSR read address
- csr_rdata  out  32  read data, combinational
- csr_hit  out  1  csr_raddr lies in this block's map, combinational
- inst_commit  in  1  one instruction retired this cycle
- events  in  NUM_EVT  per-cycle event pulses; bit 0 is unused
- ovf_pending  out  NUM_CNT  OF flag of each implemented counter
- ovf_irq  out  1  registered OR over (OF & OVFIE) of implemented counters

## Operation
- Map: B00/B80 mcycle lo/hi; B02/B82 minstret lo/hi; B03+i/B83+i counter i lo/hi; 323+i mhpmevent; 320 mcountinhibit.
- Hit range: B00–B1F, B80–B9F, 320–33F. Unimplemented counters and events in range read 0, ignore writes, and hit=1. B01/B81 (time) are not owned here: hit=0.
- Hi read returns counter[CNT_W-1:32] zero-extended. Hi writes keep only bits CNT_W-33:0.
- mhpmevent: [7:0] SEL, [30] OVFIE, [31] OF; other bits read 0. All three fields are writable.
- mcountinhibit: writable bits 0, 2 and 3..3+NUM_CNT-1; all other bits read 0.
- mcycle increments every cycle unless inhibit[0] is set.
- minstret increments on inst_commit unless inhibit[2] is set.
- Counter i increments when SEL≠0, SEL<NUM_EVT, events[SEL]=1, and inhibit[3+i]=0. Increment is +1 per cycle.
- Wrap: all-ones plus 1 gives 0. Counter wrap sets that counter's OF. mcycle and minstret wrap silently.
- Write to a counter half replaces that half. The other half holds, and no increment occurs that cycle.
- Write to mhpmevent in the same cycle as an overflow: the OF bit is set to 1 (hardware set wins); SEL and OVFIE take wdata.
- Write to mcountinhibit takes effect on increments from the next cycle.
- Read bypass: if csr_wen=1 and csr_waddr=csr_raddr in the hit range, csr_rdata = written value masked as stored. Otherwise csr_rdata is the current register value (pre-update).
- Non-hit address: csr_rdata=0.

## Timing
- Reset: all counters, mhpmevents and mcountinhibit are 0. ovf_pending=0 and ovf_irq=0. csr_rdata follows csr_raddr combinationally.
- Counter update: a qualifying event in cycle N is visible on read in cycle N+1.
- OF is set at the edge where the wrap occurs. ovf_irq rises one cycle after OF is visible, i.e. 2 edges after the wrapping increment. It is level and stays high until OF or OVFIE is cleared by software, then drops one cycle later.
- A write during reset is ignored; reset dominates everything.
- Asserting reset mid-count clears the counter at that edge.

## Test plan
- Reset, then read B00, B02, B03 and 323 on consecutive cycles → values 1/0/0/0 as appropriate (mcycle counting from 0); hit=1; ovf_irq=0.
- Write B03=FFFF_FFFE and B83=FFFF_FFFF, write 323=0x4000_0005, then hold events[5]=1 → counter passes FFFF_FFFF_FFFF_FFFF, wraps to 0, OF=1, ovf_pending[0]=1; ovf_irq=1 two edges after the wrap.
- With inst_commit=1 every cycle, write 320=0x4 → minstret freezes from the next cycle; clear the bit → counting resumes.
- Write B80=0x12 while mcycle runs; read B80 in the same cycle → rdata=0x12 (bypass). mcycle low half does not increment that cycle.
- With NUM_CNT=2: read B07 → 0, hit=1; write B07 → no effect. Read B01 → hit=0, rdata=0.
- Software write 323=0 on the wrap cycle → OF reads 1; SEL=0; counting stops.
